// File: rtl/elec_angle_reducer_if.sv
// Stream bundle for the electrical-angle reducer: position in, reduced angle/sector out.
// Handshake: a word moves on a rising edge where valid and ready are both high; the
// producer holds valid and its data steady until that edge, and ready may depend on nothing upstream.
interface elec_angle_reducer_if #(
  parameter int WIDTH = 13
);
  logic [WIDTH-1:0] pos_in;
  logic             in_valid;
  logic             in_ready;
  logic [10:0]      elec_angle;
  logic [2:0]       pole_index;
  logic [2:0]       sector;
  logic [7:0]       sector_offset;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output pos_in, in_valid, out_ready,
    input  in_ready, elec_angle, pole_index, sector, sector_offset, out_valid
  );

  modport slave (
    input  pos_in, in_valid, out_ready,
    output in_ready, elec_angle, pole_index, sector, sector_offset, out_valid
  );
endinterface

// File: rtl/elec_angle_reducer.sv
// Reduces a raw 13-bit position modulo one electrical cycle, then splits the angle into
// a six-step sector and offset using one restoring compare-subtract per clock.
module elec_angle_reducer #(
  parameter int WIDTH        = 13,
  parameter int CYCLE_TICKS  = 1170,
  parameter int SECTOR_TICKS = 195
) (
  input  logic                    clk,
  input  logic                    reset,
  elec_angle_reducer_if.slave     bus,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R2   = 3'd1,
    R1   = 3'd2,
    R0   = 3'd3,
    S2   = 3'd4,
    S1   = 3'd5,
    S0   = 3'd6,
    DONE = 3'd7
  } state_t;

  // Divisor multiples sized to the full datapath width so 4680 is never truncated.
  localparam logic [WIDTH-1:0] K_R2 = WIDTH'(4 * CYCLE_TICKS);
  localparam logic [WIDTH-1:0] K_R1 = WIDTH'(2 * CYCLE_TICKS);
  localparam logic [WIDTH-1:0] K_R0 = WIDTH'(CYCLE_TICKS);
  localparam logic [WIDTH-1:0] K_S2 = WIDTH'(4 * SECTOR_TICKS);
  localparam logic [WIDTH-1:0] K_S1 = WIDTH'(2 * SECTOR_TICKS);
  localparam logic [WIDTH-1:0] K_S0 = WIDTH'(SECTOR_TICKS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [10:0]      angle_q, angle_d;
  logic [2:0]       pole_q, pole_d;
  logic [2:0]       sector_q, sector_d;
  logic [7:0]       offset_q, offset_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH-1:0] step_k;
  logic             step_ge;
  logic [WIDTH-1:0] step_r;

  // One shared restoring step; only the divisor changes with the state.
  always_comb begin
    step_k = '0;
    case (state_q)
      R2:      step_k = K_R2;
      R1:      step_k = K_R1;
      R0:      step_k = K_R0;
      S2:      step_k = K_S2;
      S1:      step_k = K_S1;
      S0:      step_k = K_S0;
      default: step_k = '0;
    endcase
    step_ge = (r_q >= step_k);
    step_r  = step_ge ? (r_q - step_k) : r_q;
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    angle_d     = angle_q;
    pole_d      = pole_q;
    sector_d    = sector_q;
    offset_d    = offset_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          r_d      = bus.pos_in;
          pole_d   = '0;
          sector_d = '0;
          state_d  = R2;
        end
      end
      R2: begin
        r_d       = step_r;
        pole_d[2] = step_ge;
        state_d   = R1;
      end
      R1: begin
        r_d       = step_r;
        pole_d[1] = step_ge;
        state_d   = R0;
      end
      R0: begin
        r_d       = step_r;
        pole_d[0] = step_ge;
        angle_d   = step_r[10:0];
        state_d   = S2;
      end
      S2: begin
        r_d         = step_r;
        sector_d[2] = step_ge;
        state_d     = S1;
      end
      S1: begin
        r_d         = step_r;
        sector_d[1] = step_ge;
        state_d     = S0;
      end
      S0: begin
        r_d         = step_r;
        sector_d[0] = step_ge;
        offset_d    = step_r[7:0];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      angle_q     <= '0;
      pole_q      <= '0;
      sector_q    <= '0;
      offset_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      angle_q     <= angle_d;
      pole_q      <= pole_d;
      sector_q    <= sector_d;
      offset_q    <= offset_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.elec_angle    = angle_q;
  assign bus.pole_index    = pole_q;
  assign bus.sector        = sector_q;
  assign bus.sector_offset = offset_q;
  assign bus.out_valid     = out_valid_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_elec_angle_reducer.sv
// Bench for elec_angle_reducer: fixed vectors, corner sequences (backpressure, abort)
// and random positions checked against a divide/modulo reference model.
module tb_elec_angle_reducer;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  elec_angle_reducer_if bus_if ();

  elec_angle_reducer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [12:0] pos;
    logic [10:0] angle;
    logic [2:0]  pole;
    logic [2:0]  sector;
    logic [7:0]  offset;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input int p);
    int a;
    a = p % 1170;
    return {5'd0, 11'(a), 3'(p / 1170), 3'(a / 195), 8'(a % 195), 2'd0};
  endfunction

  function automatic logic [31:0] pack_out();
    return {5'd0, bus_if.elec_angle, bus_if.pole_index, bus_if.sector,
            bus_if.sector_offset, 2'd0};
  endfunction

  // ---------------- driver ----------------
  // Presents p, counts edges up to out_valid, returns the result word; optionally
  // keeps out_ready high the whole time and/or completes the output handshake.
  task automatic do_op(input logic [12:0] p, input bit hold_ready, input bit release_out,
                       output logic [31:0] res);
    int  edges;
    bit  busy_err;
    edges    = 0;
    busy_err = 0;
    while (!bus_if.in_ready && edges < 20) begin
      tick();
      edges++;
    end
    chk("in_ready_before_op", int'(bus_if.in_ready), 1);
    bus_if.out_ready = hold_ready;
    bus_if.pos_in    = p;
    bus_if.in_valid  = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.pos_in   = 13'($urandom_range(0, 8191));
    edges = 1;
    while (!bus_if.out_valid && edges < 20) begin
      if (bus_if.in_ready) busy_err = 1;
      bus_if.pos_in = 13'($urandom_range(0, 8191));
      tick();
      edges++;
    end
    chk("in_ready_low_busy", int'(busy_err), 0);
    chk("latency_edges", edges, 7);
    chk("in_ready_in_done", int'(bus_if.in_ready), 0);
    res = pack_out();
    if (release_out) begin
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
      chk("out_valid_dropped", int'(bus_if.out_valid), 0);
      chk("in_ready_after_done", int'(bus_if.in_ready), 1);
    end
  endtask

  task automatic chk_result(input string name, input logic [31:0] act, input vec_t v);
    chk({name, "_angle"},  int'(act[26:16]), int'(v.angle));
    chk({name, "_pole"},   int'(act[15:13]), int'(v.pole));
    chk({name, "_sector"}, int'(act[12:10]), int'(v.sector));
    chk({name, "_offset"}, int'(act[9:2]),   int'(v.offset));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] res;
    logic [31:0] held;
    bit          vflag;

    vecs.push_back('{13'd292,  11'd292,  3'd0, 3'd1, 8'd97});
    vecs.push_back('{13'd8191, 11'd1,    3'd7, 3'd0, 8'd1});
    vecs.push_back('{13'd1170, 11'd0,    3'd1, 3'd0, 8'd0});
    vecs.push_back('{13'd0,    11'd0,    3'd0, 3'd0, 8'd0});
    vecs.push_back('{13'd7900, 11'd880,  3'd6, 3'd4, 8'd100});
    vecs.push_back('{13'd5000, 11'd320,  3'd4, 3'd1, 8'd125});
    vecs.push_back('{13'd1169, 11'd1169, 3'd0, 3'd5, 8'd194});
    vecs.push_back('{13'd8190, 11'd0,    3'd7, 3'd0, 8'd0});
    vecs.push_back('{13'd195,  11'd195,  3'd0, 3'd1, 8'd0});
    vecs.push_back('{13'd194,  11'd194,  3'd0, 3'd0, 8'd194});

    reset            = 1'b1;
    bus_if.pos_in    = '0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_outputs", int'(pack_out()), 0);
    chk("rst_out_valid", int'(bus_if.out_valid), 0);
    chk("rst_in_ready", int'(bus_if.in_ready), 1);
    chk("rst_state", int'(dbg_state), 0);

    // Fixed vectors, with out_ready either held high or given only in DONE.
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].pos, bit'(i % 2), 1'b1, res);
      chk_result($sformatf("vec%0d", vecs[i].pos), res, vecs[i]);
    end

    // Backpressure: 20 cycles of out_ready=0 with noise on the input side.
    do_op(13'd7900, 1'b0, 1'b0, held);
    for (int c = 0; c < 20; c++) begin
      bus_if.pos_in   = 13'($urandom_range(0, 8191));
      bus_if.in_valid = 1'($urandom_range(0, 1));
      tick();
      chk("bp_hold_outputs", int'(pack_out()), int'(held));
      chk("bp_out_valid", int'(bus_if.out_valid), 1);
      chk("bp_in_ready", int'(bus_if.in_ready), 0);
    end
    chk("bp_held_value", int'(held), int'(model(7900)));
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    chk("bp_release_idle", int'(bus_if.in_ready), 1);
    chk("bp_release_valid", int'(bus_if.out_valid), 0);
    tick();
    chk("bp_nothing_accepted", int'(dbg_state), 0);

    // Abort: reset lands between edges while the operation on 5000 sits in S1.
    bus_if.pos_in   = 13'd5000;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    repeat (4) tick();
    chk("abort_in_s1", int'(dbg_state), 5);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_outputs", int'(pack_out()), 0);
    chk("abort_out_valid", int'(bus_if.out_valid), 0);
    chk("abort_in_ready", int'(bus_if.in_ready), 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    vflag = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus_if.out_valid) vflag = 1;
    end
    chk("abort_no_valid_pulse", int'(vflag), 0);
    do_op(13'd5000, 1'b0, 1'b1, res);
    chk_result("after_abort", res, vecs[5]);

    // Random positions against the divide/modulo model.
    for (int i = 0; i < 40; i++) begin
      logic [12:0] p;
      p = 13'($urandom_range(0, 8191));
      exp_q.push_back(model(int'(p)));
      do_op(p, bit'($urandom_range(0, 1)), 1'b1, res);
      chk($sformatf("rand_pos%0d", p), int'(res), int'(exp_q.pop_front()));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends with its summary.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
